// File: rtl/uart_pkg.sv
// Shared UART types and helpers, imported by the receiver (and a future transmitter).
package uart_pkg;

  // Receiver frame-recovery states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned cpb(input int unsigned clock_freq, input int unsigned baud);
    return (clock_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data while not empty.
// A pop in the same cycle as a push into a full FIFO frees the slot for that push.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PtrW + 1)'(Depth));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Storage: cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a show-ahead byte FIFO
// drained over a valid/ready handshake. Reports framing errors and overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 921600,
  parameter int unsigned CLOCK_FREQ = 30000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    data,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned Cpb  = cpb(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned CntW = $clog2(Cpb);

  logic            rx_meta_q;
  logic            rx_s;
  uart_rx_state_e  state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            overflow_q;
  logic            stop_tick;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Frame recovery: start qualified at half a bit, then one sample per bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == CntW'(Half - 1)) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            // Line back high at mid-start means a glitch: drop it silently.
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntW'(Cpb - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntW'(Cpb - 1)) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          // Wait out a held-low line so it reports only one error.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Push on the stop-sample edge itself so the byte lands in the same cycle.
  assign stop_tick = (state_q == StStop) && (cnt_q == CntW'(Cpb - 1));
  assign push      = stop_tick && rx_s;
  assign pop       = data_valid && data_ready;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end else if (overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign data_valid = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scenario tasks plus a byte scoreboard.
module tb_uart_rx_fifo;

  localparam int ClockFreq = 30000000;
  localparam int BaudRate  = 921600;
  localparam int Depth     = 8;
  localparam int Cpb       = (ClockFreq + BaudRate / 2) / BaudRate;
  localparam int Half      = Cpb / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overflow;
  logic [3:0] fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int pops = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo #(
    .BAUD_RATE  (BaudRate),
    .CLOCK_FREQ (ClockFreq),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .fifo_count   (fifo_count)
  );

  // Compares every handshake against the expected-byte queue; counts frame_err pulses.
  task automatic scoreboard();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (!reset && data_valid && data_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_pop: got data=%02h, required no byte (queue empty)", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            bad++;
            $display("FAIL scoreboard_data: got %02h, required %02h", data, e);
          end
        end
        pops++;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the stop bit (no gap).
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (Cpb) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h, required 00", data); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int fe0, vc;
    logic found;
    logic [7:0] vd;
    data_ready = 1'b1;
    fe0 = fe_cnt;
    found = 1'b0;
    vc = 0;
    vd = '0;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          if (data_valid) begin
            found = 1'b1;
            vc = cyc;
            vd = data;
          end
        end
      end
    join
    total++; if (!found) begin bad++; $display("FAIL basic_valid_seen: got none, required data_valid within 400 cycles"); end
    total++; if (vc != t0 + 2 + Half + 9 * Cpb) begin bad++; $display("FAIL basic_latency: got edge %0d, required %0d", vc - t0, 2 + Half + 9 * Cpb); end
    total++; if (vd !== 8'hA5) begin bad++; $display("FAIL basic_data: got %02h, required a5", vd); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL basic_no_frame_err: got %0d pulses, required 0", fe_cnt - fe0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drained: got %0d pending, required 0", exp_q.size()); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL basic_count: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_glitch();
    int fe0, p0;
    data_ready = 1'b1;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL glitch_count: got %0d, required 0", fifo_count); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %b, required 0", data_valid); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL glitch_frame_err: got %0d pulses, required 0", fe_cnt - fe0); end
    p0 = pops;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    total++; if (pops - p0 != 1) begin bad++; $display("FAIL glitch_next_frame: got %0d pops, required 1", pops - p0); end
  endtask

  task automatic test_frame_err();
    int fe0, p0;
    data_ready = 1'b1;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (1000) @(posedge clk);
    #1;
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL ferr_pulses: got %0d, required 1", fe_cnt - fe0); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL ferr_count: got %0d, required 0", fifo_count); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    p0 = pops;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    total++; if (pops - p0 != 1) begin bad++; $display("FAIL ferr_recover: got %0d pops, required 1", pops - p0); end
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL ferr_recover_pulses: got %0d, required 1", fe_cnt - fe0); end
  endtask

  task automatic test_overflow();
    int p0;
    logic done;
    data_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d, required 8", fifo_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL ovf_head: got %02h, required 00", data); end
    data_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (fifo_count == 4'd0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    total++; if (pops - p0 != 8) begin bad++; $display("FAIL ovf_drain: got %0d pops, required 8", pops - p0); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
  endtask

  task automatic test_full_pop();
    int p0, g;
    logic done;
    data_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'h99);
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
    g = 0;
    fork
      send_frame(8'h99, 1'b1);
      begin
        #1;
        while (cyc != t0 + 314 && g < 400) begin
          @(posedge clk);
          #1;
          g++;
        end
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
      end
    join
    total++; if (g >= 400) begin bad++; $display("FAIL fullpop_timeout: got %0d cycles, required < 400", g); end
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fullpop_count: got %0d, required 8", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
    total++; if (pops - p0 != 1) begin bad++; $display("FAIL fullpop_pop: got %0d pops, required 1", pops - p0); end
    data_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (fifo_count == 4'd0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    total++; if (pops - p0 != 9) begin bad++; $display("FAIL fullpop_drain: got %0d pops, required 9", pops - p0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fullpop_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int p0;
    logic [7:0] partial;
    partial = 8'h77;
    data_ready = 1'b0;
    send_frame(8'h44, 1'b1);
    total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL rmid_prefill: got %0d, required 1", fifo_count); end
    rx = 1'b0;
    repeat (Cpb) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", data_valid); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rmid_count: got %0d, required 0", fifo_count); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %02h, required 00", data); end
    total++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rmid_flags: got ovf=%b ferr=%b, required 0 0", overflow, frame_err); end
    reset = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    data_ready = 1'b1;
    p0 = pops;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    total++; if (pops - p0 != 1) begin bad++; $display("FAIL rmid_after: got %0d pops, required 1", pops - p0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
